reg1_out_deser: RTL and testbench
=================================

REG1_OUT_DESER -- requirements
Module: reg1_out_deser

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits (min 2).
REQ-002 SHALL have parameter SYNC_WORD, default 8'hA5, DATA_W-bit frame-alignment pattern.
REQ-003 SHALL have parameter FRAME_WORDS, default 4, data words per frame after sync (min 1).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of 2, min 2).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port din  input  1  serial bit from the upstream register stage output.
REQ-008 SHALL have port din_en  input  1  qualifier; din is sampled only on edges where din_en=1.
REQ-009 SHALL have port m_data  output  DATA_W  head-of-FIFO word.
REQ-010 SHALL have port m_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port m_ready  input  1  consumer accepts m_data when m_valid=1.
REQ-012 SHALL have port locked  output  1  high while in DATA state.
REQ-013 SHALL have port overflow  output  1  sticky: a word was dropped.

Function
REQ-014 SHALL implement a two-state FSM, HUNT and DATA; the reset state is HUNT.
REQ-015 In HUNT, every sampled bit SHALL shift MSB-first into a DATA_W-bit shift register: new value = {sr[DATA_W-2:0], din}.
REQ-016 HUNT->DATA SHALL occur on the sampling edge where the new shift value equals SYNC_WORD; the bit counter and word counter SHALL clear on that edge.
REQ-017 In DATA, sampled bits SHALL assemble MSB-first; the DATA_W-th bit SHALL complete the word.
REQ-018 On the completing edge, the full word including that bit SHALL push into the FIFO, and m_valid SHALL be high after that edge (1-cycle latency from last bit).
REQ-019 After FRAME_WORDS completed words, DATA->HUNT SHALL occur on the last completing edge; the shift register SHALL clear to 0.
REQ-020 A sync pattern appearing inside DATA SHALL be treated as data, with no re-alignment.
REQ-021 Edges with din_en=0 SHALL leave all shift/count state unchanged.
REQ-022 A pop SHALL occur on an edge where m_valid=1 and m_ready=1; m_data SHALL then advance to the next entry.
REQ-023 When full, a push SHALL be accepted only if a pop occurs on the same edge; otherwise the word SHALL be dropped and overflow set.
REQ-024 Simultaneous push and pop on an empty FIFO SHALL not occur (m_valid=0, so no pop); the push SHALL proceed normally.
REQ-025 The FIFO SHALL preserve order; pointer wrap-around SHALL be modulo FIFO_DEPTH, using an extra MSB for full/empty.
REQ-026 A dropped word SHALL still count toward FRAME_WORDS.
REQ-027 m_data SHALL be stable while m_valid=1 and m_ready=0.

Reset
REQ-028 While rst=1, the following SHALL hold after the edge: state=HUNT, sr=0, counters=0, FIFO empty, m_valid=0, m_data=0, locked=0, overflow=0.
REQ-029 rst asserted mid-frame or with FIFO contents SHALL discard all in-flight and queued words; rst SHALL take priority over din_en and m_ready.
REQ-030 overflow SHALL clear only by rst.

Structure
REQ-031 Package reg1_deser_pkg SHALL hold the state enum (HUNT, DATA) and the parameter defaults.
REQ-032 The FIFO SHALL be a sub-module reg1_sync_fifo (push/pop/full/empty, parameterised width and depth); the FSM and shift logic SHALL reside in reg1_out_deser.

Verification
REQ-033 Stream A5,11,22,33,44 with din_en=1 and m_ready=1: locked rises on the edge of the 8th sync bit; outputs are 11,22,33,44 in order; locked falls after the 44 word; each m_valid asserts 1 cycle after its last bit.
REQ-034 Random 40 bits containing no A5, then A5,DE,AD,BE,EF: no output before sync; then DE,AD,BE,EF.
REQ-035 din_en toggling 1/0 every cycle with frame A5,01,02,03,04: results identical to REQ-033 apart from timing.
REQ-036 m_ready=0 with two frames (8 words): first 4 words retained; words 5-8 dropped; overflow=1; m_ready=1 then drains 4 words of frame 1.
REQ-037 FIFO full with m_ready=1 on a completing edge: push accepted, no overflow, order kept.
REQ-038 rst pulsed mid-word of frame 2 with 2 words queued: m_valid=0, locked=0, overflow=0 next cycle; a fresh A5,… frame decodes correctly.

Source files
------------

// File: rtl/reg1_deser_pkg.sv
// ============================================================================
// Module      : reg1_deser_pkg
// Description : State encoding and parameter defaults for the sync-word
//               framed serial deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg1_deser_pkg;

    localparam logic [0:0] c_st_hunt = 1'b0;
    localparam logic [0:0] c_st_data = 1'b1;

    typedef enum logic [0:0] {
        HUNT = c_st_hunt,
        DATA = c_st_data
    } state_e;

    localparam int         c_data_w      = 8;
    localparam logic [7:0] c_sync_word   = 8'hA5;
    localparam int         c_frame_words = 4;
    localparam int         c_fifo_depth  = 4;

endpackage

`default_nettype wire

// File: rtl/reg1_sync_fifo.sv
// ============================================================================
// Module      : reg1_sync_fifo
// Description : Single-clock FIFO with extra-MSB pointers; accepts a push
//               while full only when a pop retires the head on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg1_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

    // When full, the write slot is the head being popped, so both may proceed.
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (c_aw + 1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_aw + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
        end
    end

    // Storage is not reset; gating the head keeps the output at zero when empty.
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/reg1_out_deser.sv
// ============================================================================
// Module      : reg1_out_deser
// Description : Hunts for a sync word in a qualified serial stream, then
//               assembles a fixed number of MSB-first words into a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg1_out_deser
    import reg1_deser_pkg::*;
#(
    parameter int                DATA_W      = c_data_w,
    parameter logic [DATA_W-1:0] SYNC_WORD   = DATA_W'(c_sync_word),
    parameter int                FRAME_WORDS = c_frame_words,
    parameter int                FIFO_DEPTH  = c_fifo_depth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              locked,
    output logic              overflow
);

    localparam int c_bc_w = $clog2(DATA_W);
    localparam int c_wc_w = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [c_bc_w-1:0] c_bit_last  = c_bc_w'(DATA_W - 1);
    localparam logic [c_wc_w-1:0] c_word_last = c_wc_w'(FRAME_WORDS - 1);

    state_e             r_state;
    logic [DATA_W-1:0]  r_sr;
    logic [c_bc_w-1:0]  r_bit_cnt;
    logic [c_wc_w-1:0]  r_word_cnt;
    logic               r_overflow;

    logic [DATA_W-1:0]  w_sr_next;
    logic               w_sync_hit;
    logic               w_word_done;
    logic               w_frame_done;
    logic               w_pop;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;

    assign w_sr_next    = {r_sr[DATA_W-2:0], din};
    assign w_sync_hit   = din_en && (r_state == HUNT) && (w_sr_next == SYNC_WORD);
    assign w_word_done  = din_en && (r_state == DATA) && (r_bit_cnt == c_bit_last);
    assign w_frame_done = w_word_done && (r_word_cnt == c_word_last);

    assign w_pop  = m_valid && m_ready;
    // A word that cannot be stored still advances the frame count.
    assign w_drop = w_word_done && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HUNT;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (din_en) begin
                case (r_state)
                    HUNT: begin
                        r_sr <= w_sr_next;
                        if (w_sync_hit) begin
                            r_state    <= DATA;
                            r_bit_cnt  <= '0;
                            r_word_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (w_frame_done) begin
                            r_state    <= HUNT;
                            r_sr       <= '0;
                            r_bit_cnt  <= '0;
                            r_word_cnt <= '0;
                        end else if (w_word_done) begin
                            r_sr       <= w_sr_next;
                            r_bit_cnt  <= '0;
                            r_word_cnt <= r_word_cnt + c_wc_w'(1);
                        end else begin
                            r_sr       <= w_sr_next;
                            r_bit_cnt  <= r_bit_cnt + c_bc_w'(1);
                        end
                    end
                    default: begin
                        r_state <= HUNT;
                    end
                endcase
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    reg1_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_word_done),
        .i_data  (w_sr_next),
        .i_pop   (m_ready),
        .o_data  (m_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign m_valid  = !w_empty;
    assign locked   = (r_state == DATA);
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_reg1_out_deser.sv
// ============================================================================
// Module      : tb_reg1_out_deser
// Description : Directed bench for reg1_out_deser with a frame-level
//               reference model and per-cycle output comparison.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg1_out_deser;

    localparam int         c_depth = 4;
    localparam int         c_frame = 4;
    localparam logic [7:0] c_sync  = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_en;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       locked;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Reference model state: frame position, queued words, consumed words.
    bit         mlocked;
    logic [7:0] mhunt;
    logic [7:0] macc;
    int         mnb;
    int         mnw;
    bit         movf;
    logic [7:0] q[$];
    logic [7:0] popped[$];

    reg1_out_deser u_dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_en   (din_en),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .locked   (locked),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit b, input bit en, input bit rdy, input bit r);
        bit         pop;
        bit         push;
        logic [7:0] w;
        if (r) begin
            q.delete();
            mlocked = 1'b0; mhunt = '0; macc = '0; mnb = 0; mnw = 0; movf = 1'b0;
            return;
        end
        pop  = (q.size() > 0) && rdy;
        push = 1'b0;
        w    = '0;
        if (en) begin
            if (!mlocked) begin
                mhunt = {mhunt[6:0], b};
                if (mhunt == c_sync) begin
                    mlocked = 1'b1; mnb = 0; mnw = 0;
                end
            end else begin
                macc = {macc[6:0], b};
                mnb++;
                if (mnb == 8) begin
                    push = 1'b1; w = macc; mnb = 0; mnw++;
                    if (mnw == c_frame) begin
                        mlocked = 1'b0; mhunt = '0; mnw = 0;
                    end
                end
            end
        end
        if (pop) popped.push_back(q.pop_front());
        if (push) begin
            if (q.size() < c_depth) q.push_back(w);
            else movf = 1'b1;
        end
    endtask

    task automatic step(input bit b, input bit en, input bit rdy, input bit r);
        @(negedge clk);
        din = b; din_en = en; m_ready = rdy; rst = r;
        @(posedge clk);
        model_edge(b, en, rdy, r);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit tog, input bit rdy, input bit rdy_last);
        for (int i = 7; i >= 0; i--) begin
            step(v[i], 1'b1, (i == 0) ? rdy_last : rdy, 1'b0);
            if (tog) step(1'($urandom_range(0, 1)), 1'b0, rdy, 1'b0);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic check_popped(input string nm, input logic [7:0] e[$]);
        chk({nm, "_count"}, popped.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            if (i < popped.size()) chk($sformatf("%s_word%0d", nm, i), popped[i], e[i]);
        end
        popped.delete();
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_valid", m_valid, int'(q.size() > 0));
            chk("locked", locked, mlocked);
            chk("overflow", overflow, movf);
            if (q.size() > 0) chk("m_data", m_data, q[0]);
        end
    end

    initial begin
        bit         bits[48];
        bit         clean;
        logic [7:0] win;
        logic [7:0] s;

        rst = 1'b1; din = 1'b0; din_en = 1'b0; m_ready = 1'b0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk_on = 1'b1;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_locked", locked, 0);
        chk("rst_overflow", overflow, 0);

        // Basic frame: locked on 8th sync bit, valid one cycle after last bit.
        s = c_sync;
        for (int i = 7; i >= 1; i--) step(s[i], 1, 1, 0);
        #1 chk("lock_before_8th", locked, 0);
        step(s[0], 1, 1, 0);
        #1 chk("lock_at_8th", locked, 1);
        s = 8'h11;
        for (int i = 7; i >= 1; i--) step(s[i], 1, 1, 0);
        #1 chk("valid_before_last", m_valid, 0);
        step(s[0], 1, 1, 0);
        #1 chk("valid_after_last", m_valid, 1);
        chk("first_word", m_data, 8'h11);
        send_byte(8'h22, 0, 1, 1);
        send_byte(8'h33, 0, 1, 1);
        send_byte(8'h44, 0, 1, 1);
        #1 chk("unlock_after_frame", locked, 0);
        idle(3, 1);
        check_popped("frame_basic", '{8'h11, 8'h22, 8'h33, 8'h44});

        // Random prefix free of any sync match ahead of the real sync word.
        clean = 1'b0;
        for (int t = 0; t < 200 && !clean; t++) begin
            for (int i = 0; i < 40; i++) bits[i] = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) bits[40 + i] = c_sync[7 - i];
            clean = 1'b1;
            for (int e = 7; e < 47; e++) begin
                for (int k = 0; k < 8; k++) win[7 - k] = bits[e - 7 + k];
                if (win == c_sync) clean = 1'b0;
            end
        end
        if (!clean) for (int i = 0; i < 40; i++) bits[i] = 1'b0;
        for (int i = 0; i < 40; i++) step(bits[i], 1, 1, 0);
        idle(1, 1);
        chk("no_out_before_sync", popped.size(), 0);
        for (int i = 40; i < 48; i++) step(bits[i], 1, 1, 0);
        send_byte(8'hDE, 0, 1, 1);
        send_byte(8'hAD, 0, 1, 1);
        send_byte(8'hBE, 0, 1, 1);
        send_byte(8'hEF, 0, 1, 1);
        idle(3, 1);
        check_popped("frame_random", '{8'hDE, 8'hAD, 8'hBE, 8'hEF});

        // Qualifier toggling every cycle.
        send_byte(c_sync, 1, 1, 1);
        send_byte(8'h01, 1, 1, 1);
        send_byte(8'h02, 1, 1, 1);
        send_byte(8'h03, 1, 1, 1);
        send_byte(8'h04, 1, 1, 1);
        idle(3, 1);
        check_popped("frame_toggle", '{8'h01, 8'h02, 8'h03, 8'h04});

        // Back-pressure: second frame overflows.
        send_byte(c_sync, 0, 0, 0);
        send_byte(8'h10, 0, 0, 0);
        send_byte(8'h20, 0, 0, 0);
        send_byte(8'h30, 0, 0, 0);
        send_byte(8'h40, 0, 0, 0);
        send_byte(c_sync, 0, 0, 0);
        send_byte(8'h50, 0, 0, 0);
        send_byte(8'h60, 0, 0, 0);
        send_byte(8'h70, 0, 0, 0);
        send_byte(8'h80, 0, 0, 0);
        #1 chk("ovf_set", overflow, 1);
        chk("ovf_head", m_data, 8'h10);
        idle(6, 1);
        #1 chk("ovf_sticky", overflow, 1);
        check_popped("frame_ovf", '{8'h10, 8'h20, 8'h30, 8'h40});
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        #1 chk("ovf_cleared", overflow, 0);

        // Full FIFO with a pop on the completing edge.
        send_byte(c_sync, 0, 0, 0);
        send_byte(8'h10, 0, 0, 0);
        send_byte(8'h20, 0, 0, 0);
        send_byte(8'h30, 0, 0, 0);
        send_byte(8'h40, 0, 0, 0);
        send_byte(c_sync, 0, 0, 0);
        send_byte(8'h55, 0, 0, 1);
        send_byte(8'h66, 0, 1, 1);
        send_byte(8'h77, 0, 1, 1);
        send_byte(8'h88, 0, 1, 1);
        idle(6, 1);
        #1 chk("full_pop_no_ovf", overflow, 0);
        check_popped("frame_fullpop",
                     '{8'h10, 8'h20, 8'h30, 8'h40, 8'h55, 8'h66, 8'h77, 8'h88});

        // Reset mid-word with two words queued.
        send_byte(c_sync, 0, 0, 0);
        send_byte(8'hAA, 0, 0, 0);
        send_byte(8'hBB, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 1, 1);
        #1 chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_locked", locked, 0);
        chk("rst_mid_ovf", overflow, 0);
        popped.delete();
        send_byte(c_sync, 0, 1, 1);
        send_byte(8'hC3, 0, 1, 1);
        send_byte(8'h3C, 0, 1, 1);
        send_byte(8'h5A, 0, 1, 1);
        send_byte(8'hF0, 0, 1, 1);
        idle(3, 1);
        check_popped("frame_after_rst", '{8'hC3, 8'h3C, 8'h5A, 8'hF0});

        @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
